clk_monitor: RTL and testbench

CLK_MONITOR -- requirements
Module: clk_monitor

---
 rtl/clk_monitor.sv | 105 ++++++++++
 tb/tb_clk_monitor.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_monitor.sv
// Clock presence/frequency monitor: measures the half-periods of a divided clock sampled
// as data, locks after a run of in-window half-periods and latches a fault until cleared.
module clk_monitor #(
  parameter int unsigned EXPECT_HALF = 1,
  parameter int unsigned TOL         = 0,
  parameter int unsigned LOCK_CNT    = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clock_in,
  input  logic             clear,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] half_len,
  output logic             locked,
  output logic             fault
);

  localparam int unsigned GOOD_W = ($clog2(LOCK_CNT + 1) < 1) ? 1 : $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, MEASURE, LOCKED, FAULT} state_e;

  logic              s0_q, s1_q, s2_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  half_q, half_d;
  logic [GOOD_W-1:0] good_q, good_d, good_inc;
  state_e            state_q, state_d;
  logic              edge_det, in_win, timeout;

  assign edge_det = (s1_q & ~s2_q) | (~s1_q & s2_q);
  assign timeout  = (cnt_q == CNT_MAX) && !edge_det;
  assign good_inc = good_q + 1'b1;

  // Lower bound written as cnt+TOL >= EXPECT_HALF so a negative bound clamps to 0 naturally.
  assign in_win = (64'(cnt_q) + 64'(TOL) >= 64'(EXPECT_HALF)) &&
                  (64'(cnt_q) <= 64'(EXPECT_HALF) + 64'(TOL));

  always_comb begin
    cnt_d   = edge_det ? CNT_W'(1) : ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1);
    half_d  = edge_det ? cnt_q : half_q;
    state_d = state_q;
    good_d  = good_q;
    unique case (state_q)
      IDLE: begin
        if (edge_det) begin
          state_d = MEASURE;
          good_d  = '0;
        end else if (timeout) begin
          state_d = FAULT;
        end
      end
      MEASURE: begin
        if (edge_det) begin
          if (in_win) begin
            good_d = good_inc;
            if (32'(good_inc) == LOCK_CNT) state_d = LOCKED;
          end else begin
            good_d = '0;
          end
        end else if (timeout) begin
          state_d = FAULT;
        end
      end
      LOCKED: begin
        if ((edge_det && !in_win) || timeout) state_d = FAULT;
      end
      FAULT: begin
        if (clear) begin
          state_d = IDLE;
          good_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s0_q    <= 1'b0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      cnt_q   <= '0;
      half_q  <= '0;
      good_q  <= '0;
      state_q <= IDLE;
    end else begin
      s0_q    <= clock_in;
      s1_q    <= s0_q;
      s2_q    <= s1_q;
      cnt_q   <= cnt_d;
      half_q  <= half_d;
      good_q  <= good_d;
      state_q <= state_d;
    end
  end

  assign rise     = s1_q & ~s2_q;
  assign fall     = ~s1_q & s2_q;
  assign half_len = half_q;
  assign locked   = (state_q == LOCKED);
  assign fault    = (state_q == FAULT);

endmodule

// File: tb/tb_clk_monitor.sv
// Bench for clk_monitor: three parameterisations driven by one stimulus stream, each
// compared every cycle against an event-queue reference model, plus tabled scenarios.
module tb_clk_monitor;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clock_in = 1'b0;
  logic clear = 1'b0;

  logic       ra, fa, la, ka;
  logic [7:0] ha;
  logic       rb, fb, lb, kb;
  logic [3:0] hb;
  logic       rc, fc, lc, kc;
  logic [7:0] hc;

  always #5 clk = ~clk;

  clk_monitor #(.EXPECT_HALF(1), .TOL(0), .LOCK_CNT(4), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .clock_in(clock_in), .clear(clear),
    .rise(ra), .fall(fa), .half_len(ha), .locked(la), .fault(ka));

  clk_monitor #(.EXPECT_HALF(4), .TOL(1), .LOCK_CNT(4), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .clock_in(clock_in), .clear(clear),
    .rise(rb), .fall(fb), .half_len(hb), .locked(lb), .fault(kb));

  clk_monitor #(.EXPECT_HALF(4), .TOL(0), .LOCK_CNT(4), .CNT_W(8)) dut_c (
    .clk(clk), .rst(rst), .clock_in(clock_in), .clear(clear),
    .rise(rc), .fall(fc), .half_len(hc), .locked(lc), .fault(kc));

  int EH [3] = '{1, 4, 4};
  int TL [3] = '{0, 1, 0};
  int LC [3] = '{4, 4, 4};
  int MX [3] = '{255, 15, 255};

  // Reference model: a queue of level changes, each stamped with the cycle it becomes visible.
  typedef struct { int vis; bit r; } ev_t;
  ev_t evq[$];
  int  cyc;
  bit  last_s;
  int  since [3];
  int  half  [3];
  int  st    [3];   // 0 idle, 1 measuring, 2 locked, 3 fault
  int  good  [3];

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit rstb;
    int len;
    bit clr;
    int dut;
    int exp_locked;
    int exp_fault;
    int exp_half;
  } vec_t;

  function automatic logic [11:0] act(int i);
    case (i)
      0:       return {ra, fa, la, ka, ha};
      1:       return {rb, fb, lb, kb, 4'b0, hb};
      default: return {rc, fc, lc, kc, hc};
    endcase
  endfunction

  task automatic model_reset();
    evq.delete();
    cyc    = 0;
    last_s = 1'b0;
    for (int i = 0; i < 3; i++) begin
      since[i] = 0; half[i] = 0; st[i] = 0; good[i] = 0;
    end
  endtask

  task automatic model_advance();
    bit cur_edge;
    int c, lo;
    bit inw;
    cyc++;
    cur_edge = 1'b0;
    if (evq.size() > 0 && evq[0].vis == cyc - 1) begin
      cur_edge = 1'b1;
      void'(evq.pop_front());
    end
    for (int i = 0; i < 3; i++) begin
      c   = (since[i] > MX[i]) ? MX[i] : since[i];
      lo  = (EH[i] > TL[i]) ? EH[i] - TL[i] : 0;
      inw = (c >= lo) && (c <= EH[i] + TL[i]);
      case (st[i])
        0: if (cur_edge) begin st[i] = 1; good[i] = 0; end
           else if (c == MX[i]) st[i] = 3;
        1: if (cur_edge) begin
             if (inw) begin
               good[i]++;
               if (good[i] == LC[i]) st[i] = 2;
             end else good[i] = 0;
           end else if (c == MX[i]) st[i] = 3;
        2: if ((cur_edge && !inw) || (!cur_edge && c == MX[i])) st[i] = 3;
        default: if (clear) st[i] = 0;
      endcase
      if (cur_edge) begin
        half[i]  = c;
        since[i] = 1;
      end else begin
        since[i] = (c == MX[i]) ? MX[i] : c + 1;
      end
    end
    if (clock_in != last_s) begin
      evq.push_back('{vis: cyc + 1, r: clock_in});
      last_s = clock_in;
    end
  endtask

  task automatic compare_all();
    logic [11:0] exp_v, got_v;
    bit pr, pf;
    pr = (evq.size() > 0 && evq[0].vis == cyc) ? evq[0].r : 1'b0;
    pf = (evq.size() > 0 && evq[0].vis == cyc) ? !evq[0].r : 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_v = {pr, pf, st[i] == 2, st[i] == 3, 8'(half[i])};
      got_v = act(i);
      total++;
      if (got_v !== exp_v) begin
        bad++;
        $display("FAIL model_dut%0d t=%0t got=%h expected=%h (rise,fall,locked,fault,half_len)",
                 i, $time, got_v, exp_v);
      end
    end
  endtask

  task automatic check(string name, int got, int exp_val);
    total++;
    if (got != exp_val) begin
      bad++;
      $display("FAIL %s t=%0t got=%0d expected=%0d", name, $time, got, exp_val);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (!rst) model_reset();
    else      model_advance();
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b0; clock_in = 1'b0; clear = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic apply_half(int len, bit clr);
    clock_in = ~clock_in;
    for (int j = 0; j < len; j++) begin
      clear = clr && (j == 2);   // lands on the clk edge that consumes this toggle
      step();
      clear = 1'b0;
    end
  endtask

  vec_t vecs[$];

  initial begin
    logic [11:0] v;
    int steps, len;

    vecs = '{
      '{1, 4, 0, 1, 0, 0, -1},
      '{0, 4, 0, 1, 0, 0, 4},
      '{0, 5, 0, 1, 0, 0, 4},
      '{0, 3, 0, 1, 0, 0, 5},
      '{0, 4, 0, 1, 1, 0, 3},
      '{0, 7, 0, 1, 1, 0, 4},
      '{0, 4, 0, 1, 0, 1, 7},
      '{0, 4, 1, 1, 0, 0, 4},
      '{0, 4, 0, 1, 0, 0, 4},
      '{0, 4, 0, 1, 0, 0, 4},
      '{0, 4, 0, 1, 0, 0, 4},
      '{0, 4, 0, 1, 0, 0, 4},
      '{0, 4, 0, 1, 1, 0, 4},
      '{0, 20, 0, 1, 0, 1, 4},
      '{1, 4, 0, 2, 0, 0, -1},
      '{0, 4, 0, 2, 0, 0, 4},
      '{0, 4, 0, 2, 0, 0, 4},
      '{0, 6, 0, 2, 0, 0, 4},
      '{0, 4, 0, 2, 0, 0, 6},
      '{0, 4, 0, 2, 0, 0, 4},
      '{0, 4, 0, 2, 0, 0, 4},
      '{0, 4, 0, 2, 0, 0, 4},
      '{0, 4, 0, 2, 1, 0, 4}
    };

    model_reset();
    step();
    v = act(1);
    check("reset_state_b", int'(v), 0);

    foreach (vecs[k]) begin
      if (vecs[k].rstb) do_reset();
      apply_half(vecs[k].len, vecs[k].clr);
      v = act(vecs[k].dut);
      check($sformatf("vec%0d_locked", k), int'(v[9]), vecs[k].exp_locked);
      check($sformatf("vec%0d_fault", k), int'(v[8]), vecs[k].exp_fault);
      if (vecs[k].exp_half >= 0)
        check($sformatf("vec%0d_half_len", k), int'(v[7:0]), vecs[k].exp_half);
    end

    // Default parameters, clock_in toggling every clk cycle.
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      clock_in = ~clock_in;
      step();
      if (k >= 2) check("fast_edge_every_cycle", int'(ra ^ fa), 1);
      if (k == 6) check("fast_not_yet_locked", int'(la), 0);
      if (k == 7) check("fast_locked", int'(la), 1);
      if (k == 7) check("fast_half_len", int'(ha), 1);
    end

    // Asynchronous reset mid-cycle while locked.
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_locked", int'(la), 0);
    check("async_rst_pulses", int'({ra, fa}), 0);
    check("async_rst_half_len", int'(ha), 0);
    model_reset();
    step();
    clock_in = 1'b1;
    step();
    rst = 1'b1;
    step();
    step();
    check("high_at_release_rise", int'(ra), 1);

    // Randomized half-periods, clear pulses and occasional resets.
    steps = 0;
    while (steps < 4000) begin
      len = ($urandom_range(0, 1) == 0) ? 4 : int'($urandom_range(1, 20));
      clock_in = ~clock_in;
      for (int j = 0; j < len; j++) begin
        clear = ($urandom_range(0, 15) == 0);
        rst   = ($urandom_range(0, 499) != 0);
        step();
        steps++;
      end
    end
    clear = 1'b0;
    rst   = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
